// File: rtl/letc_core_pkg.sv
// Shared types for the LETC core multiply/divide unit.
// Holds the RV32M op encoding, the muldiv FSM states and small op-decode helpers.
// Purely declarative; no logic or state.
package letc_core_pkg;

  // RV funct3 encoding of the M-extension operations
  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } muldiv_state_e;

  function automatic logic op_is_div(input muldiv_op_e op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

  // rs1 is treated as signed for these ops (MUL low half is sign-agnostic)
  function automatic logic op_signed_a(input muldiv_op_e op);
    return op inside {MUL, MULH, MULHSU, DIV, REM};
  endfunction

  // rs2 is treated as signed for these ops (MULHSU keeps rs2 unsigned)
  function automatic logic op_signed_b(input muldiv_op_e op);
    return op inside {MUL, MULH, DIV, REM};
  endfunction

endpackage

// File: rtl/letc_core_muldiv_if.sv
// Request/result bundle between the E1 stage and the multiply/divide unit.
// Request side is valid/ready; result side is valid/ready with an abort (flush).
// The master drives requests and result_ready; the slave (the unit) drives the rest.
interface letc_core_muldiv_if
  import letc_core_pkg::*;
#(
  parameter int XLEN = 32
) ();

  logic             i_valid;
  logic             o_ready;
  muldiv_op_e       i_op;
  logic [XLEN-1:0]  i_rs1;
  logic [XLEN-1:0]  i_rs2;
  logic             i_flush;
  logic             o_result_valid;
  logic             i_result_ready;
  logic [XLEN-1:0]  o_result;

  modport master (
    output i_valid, i_op, i_rs1, i_rs2, i_flush, i_result_ready,
    input  o_ready, o_result_valid, o_result
  );

  modport slave (
    input  i_valid, i_op, i_rs1, i_rs2, i_flush, i_result_ready,
    output o_ready, o_result_valid, o_result
  );

endinterface

// File: rtl/letc_core_muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on a shared 2*XLEN accumulator.
// Latency: combinational.
// Backpressure: none; the caller decides when the step result is registered.
module letc_core_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,   // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
  input  logic [XLEN-1:0]   opnd_i,  // mul: multiplicand; div: divisor
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] trial;
  logic [XLEN:0] diff;

  // Multiply adds the multiplicand when the multiplier LSB is set, then shifts the
  // whole register right (carry enters the top). Divide shifts the next dividend bit
  // into the remainder and subtracts the divisor if it fits; the borrow bit decides.
  always_comb begin
    sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    trial = acc_i[2*XLEN-1:XLEN-1];
    diff  = trial - {1'b0, opnd_i};
    acc_o = '0;
    if (is_div_i) begin
      if (diff[XLEN]) begin
        acc_o = {trial[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end else begin
        acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      end
    end else begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/letc_core_muldiv.sv
// Iterative RV32M multiply/divide: magnitude datapath with BITS_PER_CYCLE steps per cycle and sign fixup.
// Latency: XLEN/BITS_PER_CYCLE + 2 edges from accept to result; divide-by-zero/overflow in 1 edge.
// Backpressure: result held in DONE until result_ready; no new request accepted until back in IDLE.
module letc_core_muldiv
  import letc_core_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1    // 1, 2 or 4; must divide XLEN
) (
  input  logic               i_clk,
  input  logic               i_rst,
  letc_core_muldiv_if.slave  bus
);

  localparam int ITER = XLEN / BITS_PER_CYCLE;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e      state_q;
  muldiv_op_e         op_q;
  logic               neg_a_q;
  logic               neg_b_q;
  logic [XLEN-1:0]    opnd_q;
  logic [2*XLEN-1:0]  acc_q;
  logic [2*XLEN-1:0]  acc_d;
  logic [CW-1:0]      cnt_q;
  logic [XLEN-1:0]    result_q;
  logic               ready_q;
  logic               valid_q;

  // accept-side decode
  logic               sign_a;
  logic               sign_b;
  logic [XLEN-1:0]    mag_a;
  logic [XLEN-1:0]    mag_b;
  logic               div_zero;
  logic               div_ovf;
  logic               special;
  logic [XLEN-1:0]    special_res;

  // fixup-side decode
  logic [2*XLEN-1:0]  prod;
  logic [XLEN-1:0]    quo;
  logic [XLEN-1:0]    rem;
  logic [XLEN-1:0]    fix_res;

  // BITS_PER_CYCLE single steps chained within one cycle
  logic [2*XLEN-1:0]  chain [0:BITS_PER_CYCLE];

  assign chain[0] = acc_q;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    letc_core_muldiv_step #(.XLEN(XLEN)) u_step (
      .is_div_i (op_is_div(op_q)),
      .acc_i    (chain[g]),
      .opnd_i   (opnd_q),
      .acc_o    (chain[g+1])
    );
  end

  assign acc_d = chain[BITS_PER_CYCLE];

  // Operand magnitudes and the divide corner cases that bypass the iteration.
  // The most-negative value maps to itself, which is its correct unsigned magnitude.
  always_comb begin
    sign_a      = op_signed_a(bus.i_op) & bus.i_rs1[XLEN-1];
    sign_b      = op_signed_b(bus.i_op) & bus.i_rs2[XLEN-1];
    mag_a       = sign_a ? -bus.i_rs1 : bus.i_rs1;
    mag_b       = sign_b ? -bus.i_rs2 : bus.i_rs2;
    div_zero    = (bus.i_rs2 == '0);
    div_ovf     = (bus.i_op inside {DIV, REM}) && (bus.i_rs1 == MOST_NEG) && (&bus.i_rs2);
    special     = op_is_div(bus.i_op) && (div_zero || div_ovf);
    special_res = '0;
    if (bus.i_op inside {DIV, DIVU}) begin
      special_res = div_zero ? '1 : bus.i_rs1;
    end else begin
      special_res = div_zero ? bus.i_rs1 : '0;
    end
  end

  // Sign fixup: product negated when operand signs differ, quotient likewise,
  // remainder follows the dividend. Unsigned operands never set the sign flags.
  always_comb begin
    prod    = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quo     = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem     = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    fix_res = '0;
    case (op_q)
      MUL:                  fix_res = prod[XLEN-1:0];
      MULH, MULHSU, MULHU:  fix_res = prod[2*XLEN-1:XLEN];
      DIV, DIVU:            fix_res = quo;
      default:              fix_res = rem;
    endcase
  end

  // Control FSM with registered handshake outputs; flush beats everything but reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      op_q     <= MUL;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
    end else if (bus.i_flush) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_valid) begin
            op_q    <= bus.i_op;
            neg_a_q <= sign_a;
            neg_b_q <= sign_b;
            cnt_q   <= CW'(ITER - 1);
            ready_q <= 1'b0;
            if (op_is_div(bus.i_op)) begin
              opnd_q <= mag_b;
              acc_q  <= {{XLEN{1'b0}}, mag_a};
            end else begin
              opnd_q <= mag_a;
              acc_q  <= {{XLEN{1'b0}}, mag_b};
            end
            if (special) begin
              result_q <= special_res;
              valid_q  <= 1'b1;
              state_q  <= DONE;
            end else begin
              state_q  <= CALC;
            end
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_q <= FIXUP;
          end
        end
        FIXUP: begin
          result_q <= fix_res;
          valid_q  <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          if (bus.i_result_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ready        = ready_q;
  assign bus.o_result_valid = valid_q;
  assign bus.o_result       = result_q;

endmodule

// File: tb/tb_letc_core_muldiv.sv
// Self-checking bench: one unit at 1 bit/cycle and one at 4 bits/cycle driven in lockstep.
// Directed vectors carry hand-computed results; a random run uses a 64-bit reference model.
// Latency is counted in negedges after the accept edge until result_valid is seen.
module tb_letc_core_muldiv;
  import letc_core_pkg::*;

  localparam logic [31:0] MOST_NEG = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  letc_core_muldiv_if #(.XLEN(32)) bus1 ();
  letc_core_muldiv_if #(.XLEN(32)) bus4 ();

  letc_core_muldiv #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut1 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus1)
  );

  letc_core_muldiv #(.XLEN(32), .BITS_PER_CYCLE(4)) u_dut4 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic vld, input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b);
    bus1.i_valid = vld; bus1.i_op = op; bus1.i_rs1 = a; bus1.i_rs2 = b;
    bus4.i_valid = vld; bus4.i_op = op; bus4.i_rs1 = a; bus4.i_rs2 = b;
  endtask

  // Reference RV32M semantics with 64-bit arithmetic
  function automatic logic [31:0] ref_md(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] as64;
    logic signed [63:0] bs64;
    logic signed [63:0] bu64s;
    logic [63:0]        au;
    logic [63:0]        bu;
    logic [63:0]        p;
    logic               ovf;
    as64  = {{32{a[31]}}, a};
    bs64  = {{32{b[31]}}, b};
    au    = {32'h0, a};
    bu    = {32'h0, b};
    bu64s = bu;
    ovf   = (a == MOST_NEG) && (b == 32'hFFFF_FFFF);
    p     = '0;
    case (op)
      MUL:    begin p = as64 * bs64;  return p[31:0];  end
      MULH:   begin p = as64 * bs64;  return p[63:32]; end
      MULHSU: begin p = as64 * bu64s; return p[63:32]; end
      MULHU:  begin p = au * bu;      return p[63:32]; end
      DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = as64 / bs64; return p[31:0];
      end
      DIVU:   begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = au / bu; return p[31:0];
      end
      REM:    begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = as64 % bs64; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = au % bu; return p[31:0];
      end
    endcase
  endfunction

  // One full transaction on both units, optionally holding result_ready low in DONE.
  task automatic run_op(input string tag, input muldiv_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit spec, input int hold);
    int lat1;
    int lat4;
    @(negedge clk);
    chk({tag, " idle ready"}, {bus1.o_ready, bus4.o_ready}, 2'b11);
    drive(1'b1, op, a, b);
    @(posedge clk);
    #1;
    drive(1'b0, op, a, b);
    lat1 = 0;
    lat4 = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (lat1 == 0 && bus1.o_result_valid) lat1 = c;
      if (lat4 == 0 && bus4.o_result_valid) lat4 = c;
      if (lat1 != 0 && lat4 != 0) break;
    end
    chk({tag, " b1 latency"}, lat1, spec ? 1 : 34);
    chk({tag, " b4 latency"}, lat4, spec ? 1 : 10);
    chk({tag, " b1 result"}, bus1.o_result, exp);
    chk({tag, " b4 result"}, bus4.o_result, exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, " hold flags"}, {bus1.o_result_valid, bus1.o_ready, bus4.o_result_valid, bus4.o_ready}, 4'b1010);
      chk({tag, " hold result"}, {bus1.o_result, bus4.o_result}, {exp, exp});
    end
    bus1.i_result_ready = 1'b1;
    bus4.i_result_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, " release"}, {bus1.o_result_valid, bus1.o_ready, bus4.o_result_valid, bus4.o_ready}, 4'b0101);
    bus1.i_result_ready = 1'b0;
    bus4.i_result_ready = 1'b0;
  endtask

  typedef struct {
    string       tag;
    muldiv_op_e  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          spec;
  } vec_t;

  vec_t vecs [12];

  initial begin
    muldiv_op_e  rop;
    logic [2:0]  rop_b;
    logic [31:0] ra;
    logic [31:0] rb;
    bit          rsp;
    bit          seen;

    vecs[0]  = '{"mul",      MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{"mulh",     MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
    vecs[2]  = '{"mulhu",    MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[3]  = '{"mulhsu",   MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{"div",      DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0};
    vecs[5]  = '{"rem",      REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{"divu",     DIVU,   32'd100,       32'd7,         32'd14,        1'b0};
    vecs[7]  = '{"remu",     REMU,   32'd100,       32'd7,         32'd2,         1'b0};
    vecs[8]  = '{"div0",     DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{"remu0",    REMU,   32'd5,         32'd0,         32'd5,         1'b1};
    vecs[10] = '{"div ovf",  DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[11] = '{"rem ovf",  REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1};

    // reset with a request pending: it must be ignored
    rst = 1'b1;
    drive(1'b1, DIVU, 32'd5, 32'd0);
    bus1.i_flush = 1'b0; bus4.i_flush = 1'b0;
    bus1.i_result_ready = 1'b0; bus4.i_result_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, MUL, 32'd0, 32'd0);
    chk("reset flags", {bus1.o_ready, bus1.o_result_valid, bus4.o_ready, bus4.o_result_valid}, 4'b1010);
    chk("reset result", {bus1.o_result, bus4.o_result}, 64'h0);
    @(negedge clk);
    chk("post-reset idle", {bus1.o_ready, bus1.o_result_valid, bus4.o_ready, bus4.o_result_valid}, 4'b1010);

    // directed vectors
    foreach (vecs[i]) begin
      run_op(vecs[i].tag, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].spec, 0);
    end

    // result backpressure
    run_op("bp mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 5);
    run_op("bp div0", DIVU, 32'd77, 32'd0, 32'hFFFF_FFFF, 1'b1, 5);

    // flush mid-calculation: b1 at its 10th CALC cycle, b4 at its 4th
    @(negedge clk);
    drive(1'b1, MULHU, 32'hFFFF_FFFF, 32'h1234_5678);
    @(posedge clk);
    #1;
    drive(1'b0, MULHU, 32'h0, 32'h0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus4.i_flush = (c == 4);
      bus1.i_flush = (c == 10);
      if (c == 5) chk("flush b4 idle", {bus4.o_ready, bus4.o_result_valid}, 2'b10);
      if (c == 9) chk("pre-flush b1 busy", {bus1.o_ready, bus1.o_result_valid}, 2'b00);
    end
    @(posedge clk);
    #1;
    bus1.i_flush = 1'b0;
    chk("flush b1 idle", {bus1.o_ready, bus1.o_result_valid}, 2'b10);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus1.o_result_valid || bus4.o_result_valid) seen = 1'b1;
    end
    chk("flush no result", seen, 1'b0);

    // flush coincident with a request discards it
    @(negedge clk);
    drive(1'b1, DIVU, 32'd9, 32'd0);
    bus1.i_flush = 1'b1; bus4.i_flush = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b0, DIVU, 32'd0, 32'd0);
    bus1.i_flush = 1'b0; bus4.i_flush = 1'b0;
    chk("flush+valid discard", {bus1.o_ready, bus1.o_result_valid, bus4.o_ready, bus4.o_result_valid}, 4'b1010);
    @(negedge clk);
    chk("flush+valid still idle", {bus1.o_ready, bus1.o_result_valid, bus4.o_ready, bus4.o_result_valid}, 4'b1010);

    run_op("after flush divu", DIVU, 32'd9, 32'd3, 32'd3, 1'b0, 0);

    // random regression against the reference model
    for (int i = 0; i < 1000; i++) begin
      rop_b = 3'($urandom_range(0, 7));
      rop   = muldiv_op_e'(rop_b);
      case ($urandom_range(0, 7))
        0: ra = 32'h0;
        1: ra = 32'hFFFF_FFFF;
        2: ra = MOST_NEG;
        3: ra = $urandom_range(0, 50);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = MOST_NEG;
        3: rb = $urandom_range(1, 50);
        default: rb = $urandom;
      endcase
      rsp = rop_b[2] && ((rb == 32'h0) || (!rop_b[0] && ra == MOST_NEG && rb == 32'hFFFF_FFFF));
      run_op($sformatf("rnd%0d op%0d a=%h b=%h", i, rop_b, ra, rb), rop, ra, rb, ref_md(rop, ra, rb), rsp, 0);
    end

    // reset mid-operation returns to IDLE and clears the held result
    @(negedge clk);
    drive(1'b1, MUL, 32'd3, 32'd5);
    @(posedge clk);
    #1;
    drive(1'b0, MUL, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid-op reset flags", {bus1.o_ready, bus1.o_result_valid, bus4.o_ready, bus4.o_result_valid}, 4'b1010);
    chk("mid-op reset result", {bus1.o_result, bus4.o_result}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/letc_core_muldiv.md
# letc_core_muldiv

Iterative integer multiply/divide unit for the LETC core execute path. It implements all eight RV32M operations over a parametrised operand width and a parametrised number of result bits retired per cycle. It sits beside the E1 ALU: E1 launches an operation with a valid/ready handshake and holds its stage stalled until the result handshake completes. The block has its own abort (flush) and result backpressure, which the single-cycle E1 datapath does not provide.

## Interface
Parameters:
- XLEN, 32, operand and result width.
- BITS_PER_CYCLE, 1, quotient/multiplier bits processed per iteration.
  - Legal values: 1, 2, 4.
  - Must divide XLEN.
  - ITER = XLEN/BITS_PER_CYCLE.

Ports:
- i_clk  in  1  clock. One clock; all state on posedge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  operation request.
- o_ready  out  1  unit can accept a request.
- i_op  in  3  muldiv_op_e, RV funct3 encoding.
- i_rs1  in  XLEN  operand A (multiplicand / dividend).
- i_rs2  in  XLEN  operand B (multiplier / divisor).
- i_flush  in  1  abort any in-flight operation.
- o_result_valid  out  1  o_result holds a completed result.
- i_result_ready  in  1  consumer accepts the result.
- o_result  out  XLEN  result.

## Operation
- FSM states: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - o_ready=1.
  - On an accept edge (i_valid & o_ready & !i_flush), latch op, operand signs, |rs1| and |rs2| (unsigned for MULHU/DIVU/REMU; rs2 unsigned for MULHSU), and clear the accumulator.
  - Special divide cases jump IDLE->DONE with the result preloaded. All other operations go IDLE->CALC with the iteration counter set to ITER-1.
- CALC:
  - Multiply: shift-add on a 2*XLEN product register, BITS_PER_CYCLE multiplier bits per cycle.
  - Divide: restoring division, BITS_PER_CYCLE quotient bits per cycle.
  - Counter decrements each cycle; at 0 go to FIXUP.
- FIXUP (one cycle): apply signs, then select the result.
  - Product is negated (2*XLEN-bit two's complement) iff the operand signs differ (signed operands only).
  - Quotient is negative iff the dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
  - Go to DONE.
- DONE:
  - o_result_valid=1 and o_result stable, o_ready=0.
  - On i_result_ready, go to IDLE.
  - There is no back-to-back accept in DONE.
- Special cases, decided at accept (one cycle to DONE):
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give rs1.
  - DIV/REM with rs1 = most-negative and rs2 = -1: DIV gives rs1; REM gives 0.
- All arithmetic is modulo 2^XLEN (or 2^(2*XLEN) for the product). The register width for sign-magnitude conversion of the most-negative value is XLEN unsigned, so no overflow occurs.
- i_flush:
  - Highest priority after reset. From any state the FSM returns to IDLE on the next edge and no result is produced.
  - A flush coincident with i_valid discards the request.
- Reset values: state IDLE, o_ready=1, o_result_valid=0, o_result=0, all internal registers 0.
- Reset asserted mid-operation behaves as a flush and also clears the datapath.

## Timing
- Accept edge = edge 0.
- Normal operation: CALC spans edges 1..ITER, FIXUP ends at edge ITER+1. o_result_valid is high after edge ITER+2 (XLEN=32, B=1 gives 34 edges; B=4 gives 10).
- Special cases: o_result_valid is high after edge 1.
- o_result_valid is held until the edge where i_result_ready=1; the state is IDLE after that edge.
- o_ready and o_result_valid are registered-state decodes only, with no combinational path from inputs.
- With i_result_ready held high, the next accept can occur one cycle after the result handshake.

## Structure
- letc_core_pkg:
  - Add typedef enum logic [2:0] muldiv_op_e: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
  - Add the FSM state enum muldiv_state_e.
- One natural sub-module: letc_core_muldiv_step, a combinational single-iteration step for both multiply and divide. The top instantiates BITS_PER_CYCLE of them in a chain via generate.
- The top holds the FSM, counter, operand/accumulator registers and the sign fixup.

## Test plan
- Reset: after i_rst held 2 cycles, o_ready=1, o_result_valid=0, o_result=0. i_valid during reset is ignored.
- Multiply, XLEN=32, B=1, each with o_result_valid exactly 34 edges after accept:
  - MUL 7 x 0xFFFFFFFD -> 0xFFFFFFEB.
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- Divide:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
  - REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14.
  - REMU 100/7 -> 2.
- Special cases, each valid after 1 edge:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000/0xFFFFFFFF -> 0.
- Flush: i_flush at the 10th CALC cycle -> next cycle IDLE, o_ready=1, o_result_valid never rises. A following DIVU 9/3 returns 3 with normal latency.
- Backpressure and param sweep:
  - Hold i_result_ready low 5 cycles in DONE -> o_result and o_result_valid stable, o_ready=0. Release -> IDLE next edge.
  - Repeat the multiply and divide scenarios with BITS_PER_CYCLE=4 (latency 10) and a random 1000-op signed/unsigned regression against a reference model.
